// File: rtl/noc_params.sv
// noc_params: shared NoC constants, flit format and link-stage defaults.
package noc_params;

    localparam int VC_NUM          = 4;
    localparam int VC_SIZE         = $clog2(VC_NUM);
    localparam int PAYLOAD_W       = 32;
    localparam int LINK_FWD_STAGES = 2;
    localparam int LINK_BWD_STAGES = 2;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef struct packed {
        flit_label_t           flit_label;
        logic [VC_SIZE-1:0]    vc_id;
        logic [PAYLOAD_W-1:0]  payload;
    } flit_t;

    typedef struct packed {
        flit_t data;
        logic  valid;
    } link_fwd_t;

endpackage

// File: rtl/pipelined_node_link_delay_line.sv
// link_delay_line: DEPTH-stage shift register with async active-low reset; DEPTH=0 is a wire.
module link_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] stg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stg <= {DEPTH{RESET_VAL}};
                end else begin
                    stg[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
                end
            end
            assign q = stg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pipelined_node_link.sv
// pipelined_node_link: retimed router-to-router link with per-VC in-flight counters.
// Optional LINK_STATS_EN adds saturating per-VC emitted-flit counters with sync clear.
module pipelined_node_link
    import noc_params::*;
#(
    parameter  int FWD_STAGES = LINK_FWD_STAGES,
    parameter  int BWD_STAGES = LINK_BWD_STAGES,
    localparam int CNT_W      = $clog2(FWD_STAGES + 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  flit_t                    data_i,
    input  logic                     is_valid_i,
    output logic [VC_NUM-1:0]        is_on_off_o,
    output logic [VC_NUM-1:0]        is_allocatable_o,
    output flit_t                    data_o,
    output logic                     is_valid_o,
    input  logic [VC_NUM-1:0]        is_on_off_i,
    input  logic [VC_NUM-1:0]        is_allocatable_i,
    output logic [VC_NUM*CNT_W-1:0]  inflight_o
`ifdef LINK_STATS_EN
    ,
    output logic [VC_NUM*32-1:0]     flit_cnt_o,
    input  logic                     stats_clr_i
`endif
);

    link_fwd_t                 fwd_in, fwd_out;
    logic [2*VC_NUM-1:0]       bwd_q;
    logic [VC_NUM-1:0]         inc, dec;
    logic [VC_NUM-1:0][CNT_W-1:0] inflight;

    assign fwd_in = '{data: data_i, valid: is_valid_i};

    link_delay_line #(.WIDTH($bits(link_fwd_t)), .DEPTH(FWD_STAGES)) u_fwd (
        .clk (clk),
        .rst (rst),
        .d   (fwd_in),
        .q   (fwd_out)
    );

    link_delay_line #(.WIDTH(2*VC_NUM), .DEPTH(BWD_STAGES)) u_bwd (
        .clk (clk),
        .rst (rst),
        .d   ({is_on_off_i, is_allocatable_i}),
        .q   (bwd_q)
    );

    assign data_o           = fwd_out.data;
    assign is_valid_o       = fwd_out.valid;
    assign is_on_off_o      = bwd_q[2*VC_NUM-1:VC_NUM];
    assign is_allocatable_o = bwd_q[VC_NUM-1:0];

    always_comb begin
        inc = '0;
        dec = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            inc[v] = is_valid_i && data_i.vc_id == VC_SIZE'(v);
            dec[v] = is_valid_o && data_o.vc_id == VC_SIZE'(v);
        end
    end

    // Bounded by FWD_STAGES since every accepted flit leaves after exactly FWD_STAGES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight <= '0;
        else for (int v = 0; v < VC_NUM; v++) inflight[v] <= inflight[v] + CNT_W'(inc[v]) - CNT_W'(dec[v]);
    end

    assign inflight_o = inflight;

`ifdef LINK_STATS_EN
    logic [VC_NUM-1:0][31:0] flit_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flit_cnt <= '0;
        else for (int v = 0; v < VC_NUM; v++)
            flit_cnt[v] <= stats_clr_i ? '0 : (dec[v] && flit_cnt[v] != '1) ? flit_cnt[v] + 32'd1 : flit_cnt[v];
    end

    assign flit_cnt_o = flit_cnt;
`endif

endmodule

// File: tb/tb_pipelined_node_link.sv
// tb_pipelined_node_link: checks a FWD=2/BWD=2 link and a FWD=0/BWD=0 link against a queue model.
module tb_pipelined_node_link;
    import noc_params::*;

    localparam int F = 2;
    localparam int B = 2;

    logic clk, rst;
    flit_t data_i, data_o, data0;
    logic valid_i, valid_o, valid0;
    logic [VC_NUM-1:0] on_i, al_i, on_o, al_o, on0, al0;
    logic [VC_NUM*2-1:0] inf_o;
    logic [VC_NUM-1:0]   inf0;
    logic stats_clr;
`ifdef LINK_STATS_EN
    logic [VC_NUM*32-1:0] fc_o, fc0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    link_fwd_t           fq[$];
    logic [2*VC_NUM-1:0] bq[$];
    logic [31:0]         st[VC_NUM];

    pipelined_node_link #(.FWD_STAGES(F), .BWD_STAGES(B)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .is_valid_i(valid_i),
        .is_on_off_o(on_o), .is_allocatable_o(al_o), .data_o(data_o), .is_valid_o(valid_o),
        .is_on_off_i(on_i), .is_allocatable_i(al_i), .inflight_o(inf_o)
`ifdef LINK_STATS_EN
        , .flit_cnt_o(fc_o), .stats_clr_i(stats_clr)
`endif
    );

    pipelined_node_link #(.FWD_STAGES(0), .BWD_STAGES(0)) dut0 (
        .clk(clk), .rst(rst), .data_i(data_i), .is_valid_i(valid_i),
        .is_on_off_o(on0), .is_allocatable_o(al0), .data_o(data0), .is_valid_o(valid0),
        .is_on_off_i(on_i), .is_allocatable_i(al_i), .inflight_o(inf0)
`ifdef LINK_STATS_EN
        , .flit_cnt_o(fc0), .stats_clr_i(stats_clr)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        fq = {};
        bq = {};
        repeat (F) fq.push_back('0);
        repeat (B) bq.push_back('0);
        for (int v = 0; v < VC_NUM; v++) st[v] = 0;
    endtask

    task automatic drive(input logic v, input int vc, input logic [31:0] pay,
                         input logic [VC_NUM-1:0] on, input logic [VC_NUM-1:0] al);
        valid_i            = v;
        data_i.flit_label  = flit_label_t'(pay[1:0]);
        data_i.vc_id       = VC_SIZE'(vc);
        data_i.payload     = pay;
        on_i               = on;
        al_i               = al;
    endtask

    task automatic settle_check();
        int c;
        #2;
        chk("valid_o", 64'(valid_o), 64'(fq[0].valid));
        if (fq[0].valid) chk("data_o", 64'(data_o), 64'(fq[0].data));
        chk("bwd_o", 64'({on_o, al_o}), 64'(bq[0]));
        for (int v = 0; v < VC_NUM; v++) begin
            c = 0;
            foreach (fq[i]) if (fq[i].valid && fq[i].data.vc_id == v) c++;
            chk("inflight", 64'(inf_o[v*2 +: 2]), 64'(c));
        end
        chk("valid0", 64'(valid0), 64'(valid_i));
        if (valid_i) chk("data0", 64'(data0), 64'(data_i));
        chk("bwd0", 64'({on0, al0}), 64'({on_i, al_i}));
        chk("inflight0", 64'(inf0), 64'(0));
`ifdef LINK_STATS_EN
        for (int v = 0; v < VC_NUM; v++) chk("flit_cnt", 64'(fc_o[v*32 +: 32]), 64'(st[v]));
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            for (int v = 0; v < VC_NUM; v++)
                if (stats_clr) st[v] = 0;
                else if (fq[0].valid && fq[0].data.vc_id == v && st[v] != 32'hFFFF_FFFF) st[v] = st[v] + 1;
            fq.push_back('{data: data_i, valid: valid_i});
            void'(fq.pop_front());
            bq.push_back({on_i, al_i});
            void'(bq.pop_front());
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        #1;
        chk("rst_valid_o", 64'(valid_o), 64'(0));
        chk("rst_inflight", 64'(inf_o), 64'(0));
        chk("rst_bwd_o", 64'({on_o, al_o}), 64'(0));
        drive(0, 0, 0, '0, '0);
        advance();
        advance();
        rst = 1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pay;
        logic        exp_v;
        logic [31:0] exp_pay;
        logic [3:0]  exp_on;
        logic [1:0]  exp_inf0;
    } vec_t;

    vec_t vecs[11];

    initial begin
        rst = 1;
        stats_clr = 0;
        drive(0, 0, 0, '0, '0);
        model_reset();
        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            vecs[i].v        = (i >= 5 && i <= 7);
            vecs[i].pay      = 32'h100 + 32'(i);
            vecs[i].exp_v    = (i >= 7 && i <= 9);
            vecs[i].exp_pay  = 32'h100 + 32'(i) - 32'd2;
            vecs[i].exp_on   = (i >= 2) ? 4'hF : 4'h0;
            vecs[i].exp_inf0 = (i == 6) ? 2'd1 : (i == 7 || i == 8) ? 2'd2 : (i == 9) ? 2'd1 : 2'd0;
        end
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, 0, vecs[i].pay, 4'hF, 4'h0);
            settle_check();
            chk($sformatf("tbl_on[%0d]", i), 64'(on_o), 64'(vecs[i].exp_on));
            chk($sformatf("tbl_al[%0d]", i), 64'(al_o), 64'(0));
            chk($sformatf("tbl_valid[%0d]", i), 64'(valid_o), 64'(vecs[i].exp_v));
            if (vecs[i].exp_v) chk($sformatf("tbl_pay[%0d]", i), 64'(data_o.payload), 64'(vecs[i].exp_pay));
            chk($sformatf("tbl_inf0[%0d]", i), 64'(inf_o[1:0]), 64'(vecs[i].exp_inf0));
            advance();
        end

        for (int i = 0; i < 10; i++) begin
            drive(1, 1, $urandom, 4'hF, 4'($urandom));
            settle_check();
            if (i >= 2) chk("vc1_hold", 64'(inf_o[3:2]), 64'(2));
            advance();
        end

        drive(1, 3, 32'hAAAA, 4'h5, 4'hA);
        settle_check();
        advance();
        drive(1, 3, 32'hBBBB, 4'h5, 4'hA);
        settle_check();
        advance();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 4'h3, 4'hC);
            settle_check();
            chk("post_rst_valid", 64'(valid_o), 64'(0));
            advance();
        end

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, VC_NUM-1), $urandom,
                  4'($urandom), 4'($urandom));
`ifdef LINK_STATS_EN
            stats_clr = ($urandom_range(0, 49) == 0);
`endif
            settle_check();
            advance();
        end
        stats_clr = 0;

`ifdef LINK_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, 2, 32'(i), '1, '1);
            settle_check();
            advance();
        end
        settle_check();
        chk("stats_vc2_3", 64'(fc_o[95:64]), 64'(3));
        drive(1, 2, 32'h4, '1, '1);
        advance();
        drive(0, 0, 0, '1, '1);
        advance();
        stats_clr = 1;
        settle_check();
        advance();
        stats_clr = 0;
        settle_check();
        chk("stats_clr_vc2", 64'(fc_o[95:64]), 64'(0));
        force dut.flit_cnt = {VC_NUM{32'hFFFF_FFFF}};
        #1;
        release dut.flit_cnt;
        for (int v = 0; v < VC_NUM; v++) st[v] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, 2, 32'h9, '1, '1);
            settle_check();
            advance();
        end
        settle_check();
        chk("stats_sat_vc2", 64'(fc_o[95:64]), 64'(32'hFFFF_FFFF));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
